gpio_intc: RTL and testbench

GPIO_INTC -- requirements
Module: gpio_intc

---
 rtl/gpio_pkg.sv | 42 ++++
 rtl/gpio_debounce.sv | 47 ++++
 rtl/gpio_intc.sv | 162 ++++++++++++++++
 tb/tb_gpio_intc.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// gpio_pkg
// Shared constants for the GPIO interrupt controller:
//   - byte offsets of every register in the 12-bit address space
//   - bit base of the switch inputs inside the unified 32-bit input vector
//   - seven-segment reset pattern (shows a "0" on active-low segments)
//   - helpers that build the implemented-bit masks for buttons and switches
package gpio_pkg;

   localparam logic [11:0] OFF_STATUS    = 12'h000;
   localparam logic [11:0] OFF_LEVEL     = 12'h004;
   localparam logic [11:0] OFF_LED       = 12'h008;
   localparam logic [11:0] OFF_IRQ_EN    = 12'h00C;
   localparam logic [11:0] OFF_EDGE_RISE = 12'h010;
   localparam logic [11:0] OFF_EDGE_FALL = 12'h014;
   localparam logic [11:0] OFF_HEX_BASE  = 12'h020;

   // Buttons occupy bits [15:0], switches start here.
   localparam int SW_BASE = 16;

   localparam logic [6:0] HEX_RST = 7'b1000000;

   // Bits [n-1:0] set: the implemented button bits.
   function automatic logic [31:0] btn_mask(input int n);
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < 16; i++) begin
         if (i < n) m[i] = 1'b1;
      end
      return m;
   endfunction

   // Bits [SW_BASE+n-1:SW_BASE] set: the implemented switch bits.
   function automatic logic [31:0] sw_mask(input int n);
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < 16; i++) begin
         if (i < n) m[SW_BASE + i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce
// Counter-based debouncer for one raw input. The level only follows the raw
// input once the raw value has differed from it for DEB_CYC consecutive
// clock edges; any return to the current level restarts the count.
// Ports:
//   clk    - clock
//   reset  - synchronous active-low reset (level and counter cleared)
//   raw    - raw input, already polarity-corrected (1 = active)
//   level  - debounced level
//   rise   - single-cycle pulse, high in the cycle whose closing edge takes level 0->1
//   fall   - single-cycle pulse, high in the cycle whose closing edge takes level 1->0
module gpio_debounce #(
   parameter int DEB_CYC = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [15:0] cnt;
   logic        hit;

   // The accepting edge: raw still disagrees and the count is complete.
   // Pulses are derived from this so that a status register sampling them
   // updates on the same edge as the level itself.
   assign hit  = (raw != level) && (cnt == 16'(DEB_CYC - 1));
   assign rise = hit & ~level;
   assign fall = hit &  level;

   always_ff @(posedge clk) begin
      if (!reset) begin
         level <= 1'b0;
         cnt   <= '0;
      end else if (raw == level) begin
         cnt <= '0;
      end else if (hit) begin
         level <= ~level;
         cnt   <= '0;
      end else begin
         cnt <= cnt + 16'd1;
      end
   end

endmodule

// File: rtl/gpio_intc.sv
// gpio_intc
// GPIO block for buttons, switches, LEDs and seven-segment digits with an
// edge-triggered, maskable interrupt. Inputs are debounced and mapped into a
// unified 32-bit vector (buttons at [15:0] as pressed=1, switches at [31:16]).
// Ports:
//   clk, reset         - clock, synchronous active-low reset
//   CS_N, RD_N, WR_N   - active-low chip select / read / write strobes
//   Addr, DataIn       - byte offset and write data
//   BUTTON, SW         - raw inputs (BUTTON 0 = pressed, SW 1 = up)
//   DataOut            - combinational read data, 0 when not reading
//   Intr               - registered active-low interrupt
//   LEDG, HEX          - LED and seven-segment outputs (HEX digit i at [7i+6:7i])
module gpio_intc
   import gpio_pkg::*;
#(
   parameter int N_BTN   = 2,
   parameter int N_SW    = 10,
   parameter int N_LED   = 10,
   parameter int N_HEX   = 4,
   parameter int DEB_CYC = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 CS_N,
   input  logic                 RD_N,
   input  logic                 WR_N,
   input  logic [11:0]          Addr,
   input  logic [31:0]          DataIn,
   input  logic [N_BTN-1:0]     BUTTON,
   input  logic [N_SW-1:0]      SW,
   output logic [31:0]          DataOut,
   output logic                 Intr,
   output logic [N_LED-1:0]     LEDG,
   output logic [7*N_HEX-1:0]   HEX
);

   localparam logic [31:0] BTN_MASK  = btn_mask(N_BTN);
   localparam logic [31:0] SW_MASK   = sw_mask(N_SW);
   localparam logic [31:0] IMPL_MASK = BTN_MASK | SW_MASK;

   // Debouncer outputs
   logic [N_BTN-1:0] btn_level, btn_rise, btn_fall;
   logic [N_SW-1:0]  sw_level,  sw_rise,  sw_fall;
   logic [31:0]      level_vec, rise_vec, fall_vec;

   // Registers
   logic [31:0]      status, irq_en, edge_rise, edge_fall;
   logic [N_LED-1:0] led;
   logic [6:0]       hex_reg [N_HEX];
   logic             intr;

   logic             we, rd_en;
   logic [31:0]      set_vec, clr_vec, status_nxt, rdata;

   // ---------------------------------------------------------------
   // Debouncers
   // ---------------------------------------------------------------
   for (genvar k = 0; k < N_BTN; k++) begin : g_btn
      gpio_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
         .clk   (clk),
         .reset (reset),
         .raw   (~BUTTON[k]),
         .level (btn_level[k]),
         .rise  (btn_rise[k]),
         .fall  (btn_fall[k])
      );
   end

   for (genvar j = 0; j < N_SW; j++) begin : g_sw
      gpio_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
         .clk   (clk),
         .reset (reset),
         .raw   (SW[j]),
         .level (sw_level[j]),
         .rise  (sw_rise[j]),
         .fall  (sw_fall[j])
      );
   end

   always_comb begin
      level_vec = '0;
      rise_vec  = '0;
      fall_vec  = '0;
      level_vec[N_BTN-1:0]     = btn_level;
      rise_vec[N_BTN-1:0]      = btn_rise;
      fall_vec[N_BTN-1:0]      = btn_fall;
      level_vec[SW_BASE +: N_SW] = sw_level;
      rise_vec[SW_BASE +: N_SW]  = sw_rise;
      fall_vec[SW_BASE +: N_SW]  = sw_fall;
   end

   // ---------------------------------------------------------------
   // Status: new edges are ORed in after the W1C so a set always wins
   // over a simultaneous clear of the same bit.
   // ---------------------------------------------------------------
   assign we      = ~CS_N & ~WR_N;
   assign rd_en   = ~CS_N & ~RD_N;
   assign set_vec = (rise_vec & edge_rise) | (fall_vec & edge_fall);
   assign clr_vec = (we && (Addr == OFF_STATUS)) ? DataIn : 32'd0;

   always_comb begin
      status_nxt = ((status & ~clr_vec) | set_vec) & IMPL_MASK;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         status    <= '0;
         irq_en    <= '0;
         edge_rise <= IMPL_MASK;
         edge_fall <= SW_MASK;
         led       <= '1;
         intr      <= 1'b1;
         for (int i = 0; i < N_HEX; i++) hex_reg[i] <= HEX_RST;
      end else begin
         status <= status_nxt;
         // Uses the current status, so Intr trails a status set by one cycle.
         intr   <= ~|(status & irq_en);
         if (we) begin
            case (Addr)
               OFF_LED:       led       <= DataIn[N_LED-1:0];
               OFF_IRQ_EN:    irq_en    <= DataIn & IMPL_MASK;
               OFF_EDGE_RISE: edge_rise <= DataIn & IMPL_MASK;
               OFF_EDGE_FALL: edge_fall <= DataIn & IMPL_MASK;
               default: ;
            endcase
            for (int i = 0; i < N_HEX; i++) begin
               if (Addr == (OFF_HEX_BASE + 12'(4 * i))) hex_reg[i] <= DataIn[6:0];
            end
         end
      end
   end

   // ---------------------------------------------------------------
   // Combinational read mux, no side effects
   // ---------------------------------------------------------------
   always_comb begin
      rdata = '0;
      if (rd_en) begin
         case (Addr)
            OFF_STATUS:    rdata = status;
            OFF_LEVEL:     rdata = level_vec;
            OFF_LED:       rdata[N_LED-1:0] = led;
            OFF_IRQ_EN:    rdata = irq_en;
            OFF_EDGE_RISE: rdata = edge_rise;
            OFF_EDGE_FALL: rdata = edge_fall;
            default:       rdata = '0;
         endcase
         for (int i = 0; i < N_HEX; i++) begin
            if (Addr == (OFF_HEX_BASE + 12'(4 * i))) rdata[6:0] = hex_reg[i];
         end
      end
   end

   assign DataOut = rdata;
   assign Intr    = intr;
   assign LEDG    = led;

   for (genvar i = 0; i < N_HEX; i++) begin : g_hex
      assign HEX[7*i +: 7] = hex_reg[i];
   end

endmodule

// File: tb/tb_gpio_intc.sv
// tb_gpio_intc
// Directed bench for gpio_intc with default parameters. Inputs are driven
// on the falling clock edge and outputs sampled there (or #1 later), away
// from the active rising edge.
// Bus handshake: a write is CS_N=0 & WR_N=0 held across one rising edge;
// a read is CS_N=0 & RD_N=0 with DataOut valid combinationally.
module tb_gpio_intc;

   logic        clk;
   logic        reset;
   logic        CS_N, RD_N, WR_N;
   logic [11:0] Addr;
   logic [31:0] DataIn;
   logic [1:0]  BUTTON;
   logic [9:0]  SW;
   logic [31:0] DataOut;
   logic        Intr;
   logic [9:0]  LEDG;
   logic [27:0] HEX;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [31:0] exp_q[$];

   gpio_intc #(
      .N_BTN(2), .N_SW(10), .N_LED(10), .N_HEX(4), .DEB_CYC(16)
   ) dut (
      .clk(clk), .reset(reset), .CS_N(CS_N), .RD_N(RD_N), .WR_N(WR_N),
      .Addr(Addr), .DataIn(DataIn), .BUTTON(BUTTON), .SW(SW),
      .DataOut(DataOut), .Intr(Intr), .LEDG(LEDG), .HEX(HEX)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------
   task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
      @(negedge clk);
      CS_N = 1'b0; WR_N = 1'b0; Addr = a; DataIn = d;
      @(negedge clk);
      CS_N = 1'b1; WR_N = 1'b1;
   endtask

   // Read without consuming a clock edge.
   task automatic peek(input logic [11:0] a, output logic [31:0] d);
      CS_N = 1'b0; RD_N = 1'b0; Addr = a;
      #1 d = DataOut;
      CS_N = 1'b1; RD_N = 1'b1;
   endtask

   // ---------------------------------------------------------------
   // Tests
   // ---------------------------------------------------------------
   task automatic test_reset();
      logic [31:0] d;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      total_cnt++;
      if (Intr !== 1'b1) $display("FAIL reset_intr: got %b want 1", Intr); else pass_cnt++;
      total_cnt++;
      if (LEDG !== 10'h3FF) $display("FAIL reset_led: got %h want 3ff", LEDG); else pass_cnt++;
      total_cnt++;
      if (HEX !== {4{7'h40}}) $display("FAIL reset_hex: got %h want %h", HEX, {4{7'h40}}); else pass_cnt++;
      peek(12'h000, d);
      total_cnt++;
      if (d !== 32'h0) $display("FAIL reset_status: got %h want 0", d); else pass_cnt++;
      peek(12'h010, d);
      total_cnt++;
      if (d !== 32'h03FF0003) $display("FAIL reset_edge_rise: got %h want 03ff0003", d); else pass_cnt++;
      peek(12'h014, d);
      total_cnt++;
      if (d !== 32'h03FF0000) $display("FAIL reset_edge_fall: got %h want 03ff0000", d); else pass_cnt++;
      peek(12'h00C, d);
      total_cnt++;
      if (d !== 32'h0) $display("FAIL reset_irq_en: got %h want 0", d); else pass_cnt++;
   endtask

   task automatic test_bounce();
      logic [31:0] d;
      // Toggle every 3 cycles, last transition (press) at t=18.
      for (int t = 0; t < 19; t++) begin
         if (t % 3 == 0) BUTTON[0] = (t % 6 == 0) ? 1'b0 : 1'b1;
         @(negedge clk);
      end
      repeat (14) @(negedge clk);
      peek(12'h000, d);
      total_cnt++;
      if (d !== 32'h0) $display("FAIL bounce_early: status %h want 0 after 15 cycles", d); else pass_cnt++;
      @(negedge clk);
      peek(12'h000, d);
      total_cnt++;
      if (d !== 32'h1) $display("FAIL bounce_set: status %h want 1 after 16 cycles", d); else pass_cnt++;
      peek(12'h004, d);
      total_cnt++;
      if (d !== 32'h1) $display("FAIL bounce_level: level %h want 1", d); else pass_cnt++;
   endtask

   task automatic test_irq();
      logic [31:0] d;
      BUTTON[0] = 1'b1;
      repeat (20) @(negedge clk);
      bus_write(12'h000, 32'hFFFF_FFFF);
      bus_write(12'h00C, 32'h1);
      BUTTON[0] = 1'b0;
      repeat (16) @(negedge clk);
      peek(12'h000, d);
      total_cnt++;
      if (d !== 32'h1 || Intr !== 1'b1)
         $display("FAIL irq_set: status %h intr %b want 1/1", d, Intr);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (Intr !== 1'b0) $display("FAIL irq_assert: intr %b want 0", Intr); else pass_cnt++;
      bus_write(12'h000, 32'h1);
      peek(12'h000, d);
      total_cnt++;
      if (d !== 32'h0 || Intr !== 1'b0)
         $display("FAIL irq_w1c: status %h intr %b want 0/0", d, Intr);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (Intr !== 1'b1) $display("FAIL irq_release: intr %b want 1", Intr); else pass_cnt++;
   endtask

   task automatic test_set_wins();
      logic [31:0] d;
      BUTTON[0] = 1'b1;
      repeat (20) @(negedge clk);
      BUTTON[0] = 1'b0;
      repeat (15) @(negedge clk);
      // This cycle carries the rise pulse.
      CS_N = 1'b0; WR_N = 1'b0; Addr = 12'h000; DataIn = 32'h1;
      @(negedge clk);
      CS_N = 1'b1; WR_N = 1'b1;
      peek(12'h000, d);
      total_cnt++;
      if (d !== 32'h1) $display("FAIL set_wins: status %h want 1", d); else pass_cnt++;
      bus_write(12'h000, 32'h1);
      peek(12'h000, d);
      total_cnt++;
      if (d !== 32'h0) $display("FAIL set_wins_clear: status %h want 0", d); else pass_cnt++;
   endtask

   task automatic test_switch_fall();
      logic [31:0] d;
      BUTTON[0] = 1'b1;
      repeat (20) @(negedge clk);
      bus_write(12'h010, 32'h0);
      bus_write(12'h014, 32'h0001_0000);
      bus_write(12'h000, 32'hFFFF_FFFF);
      SW[0] = 1'b1;
      repeat (20) @(negedge clk);
      peek(12'h000, d);
      total_cnt++;
      if (d !== 32'h0) $display("FAIL sw_rise_masked: status %h want 0", d); else pass_cnt++;
      peek(12'h004, d);
      total_cnt++;
      if (d !== 32'h0001_0000) $display("FAIL sw_level: level %h want 00010000", d); else pass_cnt++;
      SW[0] = 1'b0;
      repeat (15) @(negedge clk);
      peek(12'h000, d);
      total_cnt++;
      if (d !== 32'h0) $display("FAIL sw_fall_early: status %h want 0", d); else pass_cnt++;
      @(negedge clk);
      peek(12'h000, d);
      total_cnt++;
      if (d !== 32'h0001_0000) $display("FAIL sw_fall: status %h want 00010000", d); else pass_cnt++;
   endtask

   task automatic test_regs();
      logic [31:0] d, e;
      bus_write(12'h02C, 32'h7F);
      bus_write(12'h008, 32'h155);
      total_cnt++;
      if (HEX[27:21] !== 7'h7F) $display("FAIL hex3_out: got %h want 7f", HEX[27:21]); else pass_cnt++;
      total_cnt++;
      if (HEX[6:0] !== 7'h40) $display("FAIL hex0_untouched: got %h want 40", HEX[6:0]); else pass_cnt++;
      total_cnt++;
      if (LEDG !== 10'h155) $display("FAIL led_out: got %h want 155", LEDG); else pass_cnt++;
      exp_q.push_back(32'h7F);
      exp_q.push_back(32'h155);
      exp_q.push_back(32'h0);
      peek(12'h02C, d);
      e = exp_q.pop_front();
      total_cnt++;
      if (d !== e) $display("FAIL read_hex3: got %h want %h", d, e); else pass_cnt++;
      peek(12'h008, d);
      e = exp_q.pop_front();
      total_cnt++;
      if (d !== e) $display("FAIL read_led: got %h want %h", d, e); else pass_cnt++;
      peek(12'h01C, d);
      e = exp_q.pop_front();
      total_cnt++;
      if (d !== e) $display("FAIL read_unmapped: got %h want %h", d, e); else pass_cnt++;
      // Upper bits beyond LED width are dropped.
      bus_write(12'h008, 32'hFFFF_FEAA);
      total_cnt++;
      if (LEDG !== 10'h2AA) $display("FAIL led_width: got %h want 2aa", LEDG); else pass_cnt++;
      // LEVEL is read-only.
      bus_write(12'h004, 32'hFFFF_FFFF);
      peek(12'h004, d);
      total_cnt++;
      if (d !== 32'h0) $display("FAIL level_ro: got %h want 0", d); else pass_cnt++;
      // No read strobe -> zero.
      CS_N = 1'b0; RD_N = 1'b1; Addr = 12'h008;
      #1;
      total_cnt++;
      if (DataOut !== 32'h0) $display("FAIL read_idle: got %h want 0", DataOut); else pass_cnt++;
      CS_N = 1'b1;
   endtask

   task automatic test_reset_mid_debounce();
      logic [31:0] d;
      bus_write(12'h010, 32'h1);
      bus_write(12'h000, 32'hFFFF_FFFF);
      BUTTON[0] = 1'b0;
      repeat (10) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      peek(12'h000, d);
      total_cnt++;
      if (d !== 32'h0 || Intr !== 1'b1 || LEDG !== 10'h3FF)
         $display("FAIL rst_mid_state: status %h intr %b led %h want 0/1/3ff", d, Intr, LEDG);
      else pass_cnt++;
      repeat (15) @(negedge clk);
      peek(12'h000, d);
      total_cnt++;
      if (d !== 32'h0) $display("FAIL rst_mid_early: status %h want 0", d); else pass_cnt++;
      @(negedge clk);
      peek(12'h000, d);
      total_cnt++;
      if (d !== 32'h1) $display("FAIL rst_mid_set: status %h want 1", d); else pass_cnt++;
   endtask

   // ---------------------------------------------------------------
   // Sequence and report
   // ---------------------------------------------------------------
   initial begin
      reset = 1'b0; CS_N = 1'b1; RD_N = 1'b1; WR_N = 1'b1;
      Addr = '0; DataIn = '0; BUTTON = 2'b11; SW = '0;
      @(negedge clk);
      test_reset();
      test_bounce();
      test_irq();
      test_set_wins();
      test_switch_fall();
      test_regs();
      test_reset_mid_debounce();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
